// File: rtl/enemy_lane_if.sv
// Handshake bundle between the game core and one enemy lane controller.
interface enemy_lane_if;
   logic       step;
   logic       spawn;
   logic       attack;
   logic [4:0] pos;
   logic       hit;
   logic       busy;
   logic       kill;
   logic       strike;
   logic [7:0] kill_cnt;

   modport master (
      output step, spawn, attack,
      input  pos, hit, busy, kill, strike, kill_cnt
   );

   modport slave (
      input  step, spawn, attack,
      output pos, hit, busy, kill, strike, kill_cnt
   );
endinterface

// File: rtl/enemy_lane_ctrl.sv
// Per-lane enemy controller: walk, wait-and-strike, hit/explosion hold, kill counting.
// Optional auto-respawn from IDLE is enabled by defining ENEMY_AUTO_RESPAWN_EN.
module enemy_lane_ctrl #(
   parameter int MAX_POS       = 10,
   parameter int HIT_MIN       = 6,
   parameter int HIT_HOLD      = 4,
   parameter int STRIKE_HOLD   = 3,
   parameter int RESPAWN_STEPS = 8
) (
   input  logic         clk,
   input  logic         rst,
   enemy_lane_if.slave  lane
);

   typedef enum logic [1:0] {S_IDLE, S_WALK, S_WAIT, S_HIT} state_t;

   localparam logic [4:0] MAX_P    = MAX_POS[4:0];
   localparam logic [4:0] HITMIN_P = HIT_MIN[4:0];
   localparam logic [4:0] HHOLD_P  = HIT_HOLD[4:0];
   localparam logic [4:0] SHOLD_P  = STRIKE_HOLD[4:0];

   state_t     state_q, state_d;
   logic [4:0] pos_q, pos_d;
   logic [4:0] hold_q, hold_d;
   logic [7:0] cnt_q, cnt_d;
   logic       hit_q, busy_q, kill_q, strike_q;
   logic       kill_d, strike_d, take_hit, spawn_go;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

`ifdef ENEMY_AUTO_RESPAWN_EN
   localparam logic [7:0] RESP_P = RESPAWN_STEPS[7:0];
   logic [7:0] resp_q, resp_d;
`endif

   assign take_hit = lane.attack && (pos_q >= HITMIN_P);

   always_comb begin
      state_d  = state_q;
      pos_d    = pos_q;
      hold_d   = hold_q;
      cnt_d    = cnt_q;
      kill_d   = 1'b0;
      strike_d = 1'b0;
      spawn_go = 1'b0;
`ifdef ENEMY_AUTO_RESPAWN_EN
      resp_d   = resp_q;
`endif
      case (state_q)
         S_IDLE: begin
            pos_d    = 5'd0;
            spawn_go = lane.spawn;
`ifdef ENEMY_AUTO_RESPAWN_EN
            if (lane.spawn) begin
               resp_d = 8'd0;
            end else if (lane.step) begin
               if (resp_q + 8'd1 == RESP_P) begin
                  spawn_go = 1'b1;
                  resp_d   = 8'd0;
               end else begin
                  resp_d = resp_q + 8'd1;
               end
            end
`endif
            if (spawn_go) begin
               state_d = S_WALK;
               pos_d   = 5'd1;
               hold_d  = 5'd0;
            end
         end
         S_WALK, S_WAIT: begin
            // Attack wins over step; a kill also pre-empts a strike completing this cycle.
            if (take_hit) begin
               kill_d  = 1'b1;
               cnt_d   = sat_inc(cnt_q);
               state_d = S_HIT;
               hold_d  = 5'd0;
            end else if (lane.step && state_q == S_WALK) begin
               if (pos_q < MAX_P) pos_d = pos_q + 5'd1;
               if (pos_q + 5'd1 >= MAX_P) begin
                  state_d = S_WAIT;
                  hold_d  = 5'd0;
               end
            end else if (lane.step) begin
               if (hold_q + 5'd1 >= SHOLD_P) begin
                  strike_d = 1'b1;
                  pos_d    = 5'd0;
                  hold_d   = 5'd0;
                  state_d  = S_IDLE;
`ifdef ENEMY_AUTO_RESPAWN_EN
                  resp_d   = 8'd0;
`endif
               end else begin
                  hold_d = hold_q + 5'd1;
               end
            end
         end
         S_HIT: begin
            if (lane.step) begin
               if (hold_q + 5'd1 >= HHOLD_P) begin
                  pos_d   = 5'd0;
                  hold_d  = 5'd0;
                  state_d = S_IDLE;
`ifdef ENEMY_AUTO_RESPAWN_EN
                  resp_d  = 8'd0;
`endif
               end else begin
                  hold_d = hold_q + 5'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         pos_q    <= 5'd0;
         hold_q   <= 5'd0;
         cnt_q    <= 8'd0;
         hit_q    <= 1'b0;
         busy_q   <= 1'b0;
         kill_q   <= 1'b0;
         strike_q <= 1'b0;
`ifdef ENEMY_AUTO_RESPAWN_EN
         resp_q   <= 8'd0;
`endif
      end else begin
         state_q  <= state_d;
         pos_q    <= pos_d;
         hold_q   <= hold_d;
         cnt_q    <= cnt_d;
         hit_q    <= (state_d == S_HIT);
         busy_q   <= (state_d != S_IDLE);
         kill_q   <= kill_d;
         strike_q <= strike_d;
`ifdef ENEMY_AUTO_RESPAWN_EN
         resp_q   <= resp_d;
`endif
      end
   end

   assign lane.pos      = pos_q;
   assign lane.hit      = hit_q;
   assign lane.busy     = busy_q;
   assign lane.kill     = kill_q;
   assign lane.strike   = strike_q;
   assign lane.kill_cnt = cnt_q;

endmodule
